inv_round_engine: RTL

//  Decryption counterpart of the encryption round: iteratively applies NUM_ROUNDS inverse rounds to one
//  16-byte block, one inverse round per clock, keys consumed last-to-first. Per round:

---
 rtl/inv_round_engine.sv | 108 ++++++++++
 1 files changed

// File: rtl/inv_round_engine.sv
// Iterative inverse-round engine: peels NUM_ROUNDS rounds off one 16-byte block, one per clock,
// fetching round keys last-to-first from an external combinational key store.

// Byte (r,c) of a block lives at bits [8*(4*r+c) +: 8].
// Undoes diffusion = row rotation (row r left by r) followed by column mix out[r] = in[r]^in[r+1]^in[r+2].
module inv_diffusion (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  logic [127:0] mix;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      // (1+x+x^2)^-1 = 1+x^2+x^3 over GF(2)[x]/(x^4+1)
      assign mix[8*(4*r+c) +: 8] = din[8*(4*r+c) +: 8]
                                 ^ din[8*(4*((r+2)%4)+c) +: 8]
                                 ^ din[8*(4*((r+3)%4)+c) +: 8];
      assign dout[8*(4*r+c) +: 8] = mix[8*(4*r+((c+4-r)%4)) +: 8];
    end
  end
endmodule

// Undoes substitutekey y = 7*x + 0x63 (mod 256); 183 is the inverse of 7 mod 256.
module inv_substitutekey (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    logic [7:0] t;
    assign t = din[8*i +: 8] - 8'h63;
    assign dout[8*i +: 8] = t * 8'd183;
  end
endmodule

// valid/ready: a transfer happens on a rising edge where valid && ready are both high;
// the source holds its payload stable while valid is high and ready is low.
module inv_round_engine #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0][3:0][3:0]  cipherin,
  output logic [3:0]            key_idx,
  input  logic [7:0][3:0][3:0]  key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0][3:0][3:0]  plainout,
  output logic [1:0]            dbg_state
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [127:0]         data;
  logic [3:0]           rounds_left;
  logic [127:0]         mixed;
  logic [127:0]         dif_out;
  logic [127:0]         round_out;

  assign mixed = data ^ key;

  inv_diffusion u_inv_diffusion (
    .din  (mixed),
    .dout (dif_out)
  );

  inv_substitutekey u_inv_substitutekey (
    .din  (dif_out),
    .dout (round_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data        <= '0;
      rounds_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data        <= cipherin;
            rounds_left <= 4'(NUM_ROUNDS);
            state       <= RUN;
          end
        end
        RUN: begin
          data        <= round_out;
          rounds_left <= rounds_left - 4'd1;
          if (rounds_left == 4'd1) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by state so unsampled (possibly X) inputs never reach them.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign key_idx   = (state == RUN) ? rounds_left - 4'd1 : 4'd0;
  assign plainout  = (state == DONE) ? data : '0;
  assign dbg_state = state;
endmodule
